// File: rtl/pipeline_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module : pipeline_ctrl_pkg
// Brief  : Shared stall-vector, FSM encodings and default handler address.
// Rev    : 1.0
// ============================================================================
package pipeline_ctrl_pkg;

    localparam int c_STALL_W = 6;

    // Bit order: [0]PC [1]IF/ID [2]ID/EX [3]EX/MEM [4]MEM/WB [5]WB
    localparam logic [c_STALL_W-1:0] c_STALL_NONE = 6'b000000;
    localparam logic [c_STALL_W-1:0] c_STALL_IF   = 6'b000011;
    localparam logic [c_STALL_W-1:0] c_STALL_ID   = 6'b000111;
    localparam logic [c_STALL_W-1:0] c_STALL_EX   = 6'b001111;
    localparam logic [c_STALL_W-1:0] c_STALL_MEM  = 6'b011111;

    localparam logic [1:0] c_CTRL_RUN      = 2'd0;
    localparam logic [1:0] c_CTRL_WAIT_IF  = 2'd1;
    localparam logic [1:0] c_CTRL_REDIRECT = 2'd2;

    typedef enum logic [1:0] {
        ST_RUN      = c_CTRL_RUN,
        ST_WAIT_IF  = c_CTRL_WAIT_IF,
        ST_REDIRECT = c_CTRL_REDIRECT
    } ctrl_state_t;

    localparam logic [31:0] c_EXC_VECTOR = 32'hBFC0_0380;

endpackage : pipeline_ctrl_pkg
`default_nettype wire

// File: rtl/pipeline_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module : pipeline_ctrl_if
// Brief  : Stall/flush scheduler bundle: stage requests in, freeze/redirect out.
// Rev    : 1.0
// ============================================================================
interface pipeline_ctrl_if #(
    parameter int STALL_CNT_W = 32,
    parameter int FLUSH_CNT_W = 16
);
    logic                   stall_req_if;
    logic                   stall_req_id;
    logic                   stall_req_ex;
    logic                   stall_req_mem;
    logic                   exc_flag;
    logic                   eret_flag;
    logic [31:0]            cp0_epc;
    logic [5:0]             stall;
    logic                   flush;
    logic [31:0]            flush_pc;
    logic                   redirect;
    logic [STALL_CNT_W-1:0] stall_cycles;
    logic [FLUSH_CNT_W-1:0] flush_count;

    modport master (
        output stall_req_if, stall_req_id, stall_req_ex, stall_req_mem,
        output exc_flag, eret_flag, cp0_epc,
        input  stall, flush, flush_pc, redirect, stall_cycles, flush_count
    );

    modport slave (
        input  stall_req_if, stall_req_id, stall_req_ex, stall_req_mem,
        input  exc_flag, eret_flag, cp0_epc,
        output stall, flush, flush_pc, redirect, stall_cycles, flush_count
    );
endinterface : pipeline_ctrl_if
`default_nettype wire

// File: rtl/pipeline_ctrl_stall_encoder.sv
`default_nettype none
// ============================================================================
// Module : pipeline_ctrl_stall_encoder
// Brief  : Priority encoder; the deepest stalling stage sets the freeze vector.
// Rev    : 1.0
// ============================================================================
module pipeline_ctrl_stall_encoder
    import pipeline_ctrl_pkg::*;
(
    input  wire logic                 i_req_if,
    input  wire logic                 i_req_id,
    input  wire logic                 i_req_ex,
    input  wire logic                 i_req_mem,
    output logic      [c_STALL_W-1:0] o_stall
);

    assign o_stall = i_req_mem ? c_STALL_MEM :
                     i_req_ex  ? c_STALL_EX  :
                     i_req_id  ? c_STALL_ID  :
                     i_req_if  ? c_STALL_IF  : c_STALL_NONE;

endmodule : pipeline_ctrl_stall_encoder
`default_nettype wire

// File: rtl/pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module : pipeline_ctrl
// Brief  : 5-stage stall/flush scheduler with exception/ERET redirect and counters.
// Rev    : 1.0
// ============================================================================
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR  = c_EXC_VECTOR,
    parameter int          STALL_CNT_W = 32,
    parameter int          FLUSH_CNT_W = 16
) (
    input  wire logic      clk,
    input  wire logic      rst_n,
    pipeline_ctrl_if.slave bus
);

    ctrl_state_t            r_state;
    ctrl_state_t            w_state_nxt;
    logic [31:0]            r_pend_pc;
    logic [STALL_CNT_W-1:0] r_stall_cycles;
    logic [FLUSH_CNT_W-1:0] r_flush_count;

    logic [c_STALL_W-1:0]   w_enc_stall;
    logic [c_STALL_W-1:0]   w_stall;
    logic                   w_flush;
    logic                   w_redirect;
    logic [31:0]            w_flush_pc;
    logic                   w_pend_load;
    logic                   w_take;
    logic [31:0]            w_target;

    pipeline_ctrl_stall_encoder u_stall_encoder (
        .i_req_if  (bus.stall_req_if),
        .i_req_id  (bus.stall_req_id),
        .i_req_ex  (bus.stall_req_ex),
        .i_req_mem (bus.stall_req_mem),
        .o_stall   (w_enc_stall)
    );

    // A stalled MEM stage has not really committed its exception/ERET yet.
    assign w_take   = (bus.exc_flag | bus.eret_flag) & ~bus.stall_req_mem;
    assign w_target = bus.exc_flag ? EXC_VECTOR : bus.cp0_epc;

    always_comb begin
        w_state_nxt = r_state;
        w_stall     = c_STALL_NONE;
        w_flush     = 1'b0;
        w_redirect  = 1'b0;
        w_flush_pc  = 32'h0;
        w_pend_load = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (w_take) begin
                    w_flush = 1'b1;
                    if (!bus.stall_req_if) begin
                        w_redirect = 1'b1;
                        w_flush_pc = w_target;
                    end else begin
                        w_pend_load = 1'b1;
                        w_state_nxt = ST_WAIT_IF;
                    end
                end else begin
                    w_stall = w_enc_stall;
                end
            end
            ST_WAIT_IF: begin
                w_stall = c_STALL_IF;
                if (!bus.stall_req_if) begin
                    w_state_nxt = ST_REDIRECT;
                end
            end
            ST_REDIRECT: begin
                // Second flush kills the instruction that arrived on the late fetch.
                w_flush     = 1'b1;
                w_redirect  = 1'b1;
                w_flush_pc  = r_pend_pc;
                w_state_nxt = ST_RUN;
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ST_RUN;
            r_pend_pc      <= 32'h0;
            r_stall_cycles <= '0;
            r_flush_count  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_pend_load) begin
                r_pend_pc <= w_target;
            end
            if (w_stall != c_STALL_NONE) begin
                r_stall_cycles <= r_stall_cycles + STALL_CNT_W'(1);
            end
            if (w_flush) begin
                r_flush_count <= r_flush_count + FLUSH_CNT_W'(1);
            end
        end
    end

    // Outputs are held quiet for the whole reset window, whatever the requests do.
    assign bus.stall        = rst_n ? w_stall    : c_STALL_NONE;
    assign bus.flush        = rst_n & w_flush;
    assign bus.redirect     = rst_n & w_redirect;
    assign bus.flush_pc     = rst_n ? w_flush_pc : 32'h0;
    assign bus.stall_cycles = r_stall_cycles;
    assign bus.flush_count  = r_flush_count;

endmodule : pipeline_ctrl
`default_nettype wire
